contador_extensor: RTL and testbench
====================================

# contador_extensor

Downstream cascade stage for the 4-bit `contador`. It consumes the counter's `rco` and `Q` outputs and maintains a registered upper count, so the pair forms a wider counter (16 bits by default). Mode and enable are shared with `contador`. The block also produces its own terminal-count pulse and a sticky overflow flag, so further stages can be chained.

## Interface

Parameters:
- `UPPER_W`, default 12: width of the upper count; the extended width is `UPPER_W+4`.

Ports:
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high; highest priority.
- `enable` input, 1 bit: same signal that drives `contador.enable`.
- `mode` input, 2 bits: same signal that drives `contador.mode`.
  - 00: up by 1.
  - 01: down by 1.
  - 10: up by 3.
  - 11: parallel load.
- `D_hi` input, `UPPER_W` bits: load value for the upper count.
- `rco_in` input, 1 bit: `contador.rco`; sampled high at a rising edge means the low nibble wrapped on that edge.
- `q_in` input, 4 bits: `contador.Q`, passed through as the low nibble.
- `Q_ext` output, `UPPER_W+4` bits: `{upper, q_in}`.
- `rco_ext` output, 1 bit: registered one-cycle pulse on upper-count wrap.
- `ovf` output, 1 bit: sticky overflow/underflow flag (see Configuration).

## Operation

- Registered state: `upper` (`UPPER_W` bits), `rco_ext`, `ovf`.
- Update priority at each rising edge:
  - `reset`=1: `upper`=0, `rco_ext`=0, `ovf`=0. This applies mid-operation, and a pending `rco_in` is discarded.
  - `enable`=0: `upper` and `ovf` hold; `rco_ext`=0; `rco_in` is ignored.
  - `mode`=11: `upper`=`D_hi`; `rco_ext`=0; `rco_in` is ignored. The load takes precedence over a simultaneous `rco_in`.
  - `mode`=00 or 10 with `rco_in`=1: `upper`=`upper`+1, modulo 2^`UPPER_W`.
    - An up-by-3 crossing of the nibble boundary counts as exactly one carry.
  - `mode`=01 with `rco_in`=1: `upper`=`upper`-1, modulo 2^`UPPER_W`.
  - Otherwise: hold; `rco_ext`=0.
- Wrap detection, evaluated with the pre-update value of `upper`:
  - Up modes: `upper`=all-ones and `rco_in`=1 → `upper` becomes 0 and `rco_ext`=1 for the next cycle.
  - Down mode: `upper`=0 and `rco_in`=1 → `upper` becomes all-ones and `rco_ext`=1.
  - In both cases `ovf` is set when the macro is enabled.
- `ovf` clears only on `reset`.
- Arithmetic: unsigned, width `UPPER_W`, no saturation.
- `Q_ext` low nibble is combinational from `q_in`; the upper field is the `upper` register.

## Timing

- Upper-count latency: `upper` reflects an `rco_in` sampled at edge N immediately after edge N; `Q_ext` is coherent with `contador.Q` from that edge on.
- `rco_ext` is high for exactly one cycle, the cycle after edge N. It is never high on consecutive cycles unless `rco_in` wraps on consecutive edges.
- Load: `upper`=`D_hi` after the same edge that loads `contador`, so the full `Q_ext` equals `{D_hi, D}` after one cycle.
- Reset values: `Q_ext`=`{0, q_in}`, `rco_ext`=0, `ovf`=0.
- No combinational path exists from inputs to `rco_ext` or `ovf`.

## Configuration

- Macro `CONTADOR_EXT_OVF_EN`.
- Defined: `ovf` is implemented as described, set on any upper wrap and cleared only by `reset`.
- Undefined: the `ovf` register is not built and `ovf` is tied to 0. All other behaviour is identical.

## Test plan

- Reset: hold `reset`=1 for 2 cycles with `rco_in`=1 and `enable`=1 → `upper`=0, `rco_ext`=0, `ovf`=0. After release with `mode`=00 and `q_in` counting 0→15→0, `Q_ext` reads 0x0000…0x000F, then 0x0010.
- Up wrap: load `D_hi`=0xFFF, `D`=0xE, then count up (mode 00) → `Q_ext` 0xFFFE, 0xFFFF, 0x0000. `rco_ext`=1 for exactly the cycle showing 0x0000, and `ovf`=1 (macro defined) or 0 (undefined).
- Down wrap: load `D_hi`=0x000, `D`=0x1, then `mode`=01 → `Q_ext` 0x0001, 0x0000, 0xFFFF. `rco_ext` pulses once; `ovf` stays 1 until `reset`.
- Up by 3: `D_hi`=0x123, `D`=0xE, `mode`=10 → `Q_ext` 0x123E, then 0x1241, with a single increment of `upper`.
- Enable and priority:
  - `enable`=0 with `rco_in` forced 1 for 3 cycles → `upper` unchanged, `rco_ext`=0.
  - `mode`=11 with `D_hi`=0x0A5 and `rco_in`=1 on the same edge → `upper`=0x0A5, no increment.
- Reset mid-count: `upper`=0x7FF with `rco_in`=1 and `reset`=1 on the same edge → `upper`=0, no `rco_ext` pulse.

Source files
------------

// File: rtl/contador_extensor.sv
// Cascade stage that extends the 4-bit contador with a registered upper count.
// Optional sticky wrap flag is built only when CONTADOR_EXT_OVF_EN is defined.
module contador_extensor #(
    parameter int UPPER_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [UPPER_W-1:0]   D_hi,
    input  logic                 rco_in,
    input  logic [3:0]           q_in,
    output logic [UPPER_W+3:0]   Q_ext,
    output logic                 rco_ext,
    output logic                 ovf
);

    localparam logic [1:0] MODE_UP1  = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP3  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [UPPER_W-1:0] ONE   = {{(UPPER_W-1){1'b0}}, 1'b1};
    localparam logic [UPPER_W-1:0] ZERO  = '0;
    localparam logic [UPPER_W-1:0] ONES  = '1;

    logic [UPPER_W-1:0] upper_q, upper_d;
    logic               rco_ext_q, rco_ext_d;
    logic               wrap;

    // Both up modes carry exactly once per low-nibble wrap, so they share one path.
    always_comb begin
        upper_d = upper_q;
        wrap    = 1'b0;
        if (enable) begin
            case (mode)
                MODE_LOAD: upper_d = D_hi;
                MODE_DOWN: begin
                    if (rco_in) begin
                        upper_d = upper_q - ONE;
                        wrap    = (upper_q == ZERO);
                    end
                end
                MODE_UP1, MODE_UP3: begin
                    if (rco_in) begin
                        upper_d = upper_q + ONE;
                        wrap    = (upper_q == ONES);
                    end
                end
                default: upper_d = upper_q;
            endcase
        end
        rco_ext_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upper_q   <= '0;
            rco_ext_q <= 1'b0;
        end else begin
            upper_q   <= upper_d;
            rco_ext_q <= rco_ext_d;
        end
    end

`ifdef CONTADOR_EXT_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign Q_ext   = {upper_q, q_in};
    assign rco_ext = rco_ext_q;

endmodule

// File: tb/tb_contador_extensor.sv
// Directed vector bench for contador_extensor (UPPER_W = 12, 16-bit Q_ext).
// Expected ovf follows CONTADOR_EXT_OVF_EN so the bench fits both builds.
module tb_contador_extensor;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] D_hi;
    logic        rco_in;
    logic [3:0]  q_in;
    logic [15:0] Q_ext;
    logic        rco_ext;
    logic        ovf;

    int total = 0;
    int bad   = 0;

`ifdef CONTADOR_EXT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    contador_extensor #(.UPPER_W(12)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .D_hi    (D_hi),
        .rco_in  (rco_in),
        .q_in    (q_in),
        .Q_ext   (Q_ext),
        .rco_ext (rco_ext),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  md;
        logic [11:0] dhi;
        logic        rco;
        logic [3:0]  q;
        logic [15:0] exp_q;
        logic        exp_rco;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic en, logic [1:0] md, logic [11:0] dhi,
                                logic rco, logic [3:0] q, logic [15:0] exp_q,
                                logic exp_rco, logic exp_ovf);
        vec_t v;
        v.rst = rst; v.en = en; v.md = md; v.dhi = dhi; v.rco = rco; v.q = q;
        v.exp_q = exp_q; v.exp_rco = exp_rco; v.exp_ovf = exp_ovf & OVF_EN;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [1:0] md,
                         input logic [11:0] dhi, input logic rco, input logic [3:0] q);
        reset = rst; enable = en; mode = md; D_hi = dhi; rco_in = rco; q_in = q;
    endtask

    task automatic edge_and_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b1, 2'b00, 12'h000, 1'b1, 4'h0);

        // Reset held two cycles with rco_in and enable high.
        tbl.push_back(mk(1, 1, 2'b00, 12'h000, 1, 4'h0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 12'h000, 1, 4'h0, 16'h0000, 0, 0));
        // Up wrap from 0xFFFE.
        tbl.push_back(mk(0, 1, 2'b11, 12'hFFF, 0, 4'hE, 16'hFFFE, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 12'h000, 0, 4'hF, 16'hFFFF, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 12'h000, 1, 4'h0, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 1, 2'b00, 12'h000, 0, 4'h1, 16'h0001, 0, 1));
        // Down wrap from 0x0001; ovf remains set.
        tbl.push_back(mk(0, 1, 2'b11, 12'h000, 0, 4'h1, 16'h0001, 0, 1));
        tbl.push_back(mk(0, 1, 2'b01, 12'h000, 0, 4'h0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 1, 2'b01, 12'h000, 1, 4'hF, 16'hFFFF, 1, 1));
        tbl.push_back(mk(0, 1, 2'b01, 12'h000, 0, 4'hE, 16'hFFFE, 0, 1));
        tbl.push_back(mk(1, 1, 2'b01, 12'h000, 0, 4'h0, 16'h0000, 0, 0));
        // Up by 3 across the nibble boundary: single increment.
        tbl.push_back(mk(0, 1, 2'b11, 12'h123, 0, 4'hE, 16'h123E, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 12'h000, 1, 4'h1, 16'h1241, 0, 0));
        // Disabled: rco_in ignored for three cycles.
        tbl.push_back(mk(0, 0, 2'b00, 12'h000, 1, 4'h1, 16'h1241, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 12'h000, 1, 4'h1, 16'h1241, 0, 0));
        tbl.push_back(mk(0, 0, 2'b11, 12'hABC, 1, 4'h1, 16'h1241, 0, 0));
        // Load beats a simultaneous carry; then a plain decrement.
        tbl.push_back(mk(0, 1, 2'b11, 12'h0A5, 1, 4'h3, 16'h0A53, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 12'h000, 1, 4'hF, 16'h0A4F, 0, 0));
        // Reset with a pending carry at 0x7FF.
        tbl.push_back(mk(0, 1, 2'b11, 12'h7FF, 0, 4'hF, 16'h7FFF, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 12'h000, 1, 4'h0, 16'h0000, 0, 0));
        // Wraps on consecutive edges give consecutive pulses; disable keeps ovf.
        tbl.push_back(mk(0, 1, 2'b11, 12'hFFF, 0, 4'hF, 16'hFFFF, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 12'h000, 1, 4'h0, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 1, 2'b01, 12'h000, 1, 4'hF, 16'hFFFF, 1, 1));
        tbl.push_back(mk(0, 1, 2'b00, 12'h000, 0, 4'hF, 16'hFFFF, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 12'h000, 1, 4'hF, 16'hFFFF, 0, 1));
        tbl.push_back(mk(1, 1, 2'b00, 12'h000, 0, 4'h0, 16'h0000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].md, tbl[i].dhi, tbl[i].rco, tbl[i].q);
            edge_and_settle();
            check($sformatf("vec%0d Q_ext", i), Q_ext, tbl[i].exp_q);
            check($sformatf("vec%0d rco_ext", i), {15'd0, rco_ext}, {15'd0, tbl[i].exp_rco});
            check($sformatf("vec%0d ovf", i), {15'd0, ovf}, {15'd0, tbl[i].exp_ovf});
        end

        // Count 0..15 on the low nibble, then the carry into upper.
        for (int n = 0; n < 16; n++) begin
            drive(1'b0, 1'b1, 2'b00, 12'h000, 1'b0, 4'(n));
            edge_and_settle();
            check($sformatf("count%0d Q_ext", n), Q_ext, 16'(n));
        end
        drive(1'b0, 1'b1, 2'b00, 12'h000, 1'b1, 4'h0);
        edge_and_settle();
        check("count carry Q_ext", Q_ext, 16'h0010);
        check("count carry rco_ext", {15'd0, rco_ext}, 16'd0);

        // Low nibble follows q_in between edges.
        drive(1'b0, 1'b1, 2'b00, 12'h000, 1'b0, 4'h9);
        #2;
        check("comb low nibble", Q_ext, 16'h0019);
        q_in = 4'h4;
        #1;
        check("comb low nibble change", Q_ext, 16'h0014);

        // rco_ext must drop after one cycle even with no further input activity.
        drive(1'b0, 1'b1, 2'b11, 12'hFFF, 1'b0, 4'hF);
        edge_and_settle();
        drive(1'b0, 1'b1, 2'b10, 12'h000, 1'b1, 4'h2);
        edge_and_settle();
        check("up3 wrap Q_ext", Q_ext, 16'h0002);
        check("up3 wrap rco_ext", {15'd0, rco_ext}, 16'd1);
        check("up3 wrap ovf", {15'd0, ovf}, {15'd0, OVF_EN});
        drive(1'b0, 1'b1, 2'b10, 12'h000, 1'b0, 4'h5);
        edge_and_settle();
        check("pulse end rco_ext", {15'd0, rco_ext}, 16'd0);
        check("pulse end ovf", {15'd0, ovf}, {15'd0, OVF_EN});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
